ex_muldiv_seq: RTL and testbench
================================

Name: ex_muldiv_seq

Overview:
- Multi-cycle sequencer for the RV64M multiply/divide datapath in the EX stage.
- Accepts one operation from the EX issue logic and iterates a shared shift-add multiplier / restoring divider one bit per cycle.
- Applies RV64 word (*W) operand narrowing and 32-to-64 sign-extension of results.
- Holds the result until the EX stage consumes it, and stalls the pipeline via busy.

Parameters:
- DATA_W, 64, operand/result width; word ops always use the low 32 bits.
- CNT_W, 7, iteration counter width; must hold DATA_W.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- mdu_valid  input  1  request valid
- mdu_ready  output  1  block idle and able to accept
- mdu_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- inst_word  input  1  *W variant (MULW/DIVW/DIVUW/REMW/REMUW)
- mdu_src1  input  DATA_W  rs1 value
- mdu_src2  input  DATA_W  rs2 value
- mdu_flush  input  1  pipeline flush; kill any in-flight op
- mdu_res_valid  output  1  result valid
- mdu_res_ready  input  1  EX consumes result
- mdu_res_data  output  DATA_W  result
- mdu_busy  output  1  stall request: state != IDLE

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset: state=IDLE, mdu_ready=1, mdu_res_valid=0, mdu_res_data=0, mdu_busy=0.
- Accept: in IDLE when mdu_valid=1 and mdu_flush=0. Latch op, word flag, and operand magnitudes plus sign flags. Counter N = 32 if inst_word else 64.
- Operand prep, word ops: src[31:0] sign-extended (signed ops) or zero-extended (DIVUW/REMUW).
- Operand prep, signed ops: magnitudes are used; the final result is negated when the sign flags require it.
- Transitions: MUL: one product bit per cycle, 2*DATA_W accumulator, count down to 0, then DONE. DIV: restoring divide, one quotient bit per cycle, then DONE.
- Sign fixup and result selection are registered on the DONE-entry edge.
- Latency: accept at cycle T → mdu_res_valid=1 at T+N+1 (T+65 dword, T+33 word).
- Result select:
  - MUL: low half of the product.
  - MULH/MULHSU/MULHU: high half, signedness per op (MULHSU: rs1 signed, rs2 unsigned).
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Word ops: result = {32{r[31]}, r[31:0]}. inst_word with MULH/MULHSU/MULHU is illegal; decode never issues it, and the block treats it as MUL-word.
- Divide by zero: skip iteration, DONE at T+1. Quotient = all ones (word: sign-extended 0xFFFFFFFF). Remainder = dividend (word: sign-extended low 32).
- Signed overflow (DIV/REM, dividend = most negative of the operating width, divisor = -1): DONE at T+1. Quotient = dividend, remainder = 0.
- DONE: mdu_res_valid=1 and mdu_res_data held stable until mdu_res_ready=1, then IDLE next cycle.
  - mdu_ready=0 in DONE; there is no back-to-back accept on the handshake cycle.
- Flush: mdu_flush=1 in any state → IDLE next cycle, mdu_res_valid=0, result discarded. Flush beats an accept in the same cycle. Flush in DONE coincident with res_ready: the result counts as consumed and state goes to IDLE.
- Reset mid-operation: same as flush, plus mdu_res_data cleared to 0.
- mdu_busy = (state != IDLE); it is deasserted in the cycle after the DONE handshake.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, jump to DONE with the accumulator aligned to the remaining shift count. Latency becomes data-dependent (minimum T+2 for a nonzero multiplier; a zero multiplier gives DONE at T+1). The result is identical.
- Undefined: fixed latency N+1 for every multiply.
- Divide latency is unaffected in both cases.

Test Plan:
- MUL, src1=7, src2=-3 (0xFFFFFFFFFFFFFFFD) → res_valid at T+65 (macro off), data 0xFFFFFFFFFFFFFFEB; MULHU of the same operands → 0x0000000000000006.
- DIVW, src1=0x00000000_80000000, src2=0xFFFFFFFF_FFFFFFFF → overflow path, res_valid at T+1, data 0xFFFFFFFF80000000; REMW of the same operands → 0.
- DIVU, src2=0, src1=0x1234 → T+1, data 0xFFFFFFFFFFFFFFFF; REMU of the same operands → 0x1234.
- REM, src1=-7, src2=2 → data 0xFFFFFFFFFFFFFFFF (-1); DIVUW, src1=0xFFFFFFFF, src2=2 → T+33, data 0x000000007FFFFFFF.
- Hold res_ready=0 for 5 cycles after DONE → res_valid and data stable, busy=1, mdu_ready=0; assert res_ready → IDLE next cycle, busy=0.
- Flush at cycle T+10 of a DIV → IDLE at T+11, no res_valid; new MULW, src1=0x7FFFFFFF, src2=2, accepted at T+11 → data 0xFFFFFFFFFFFFFFFE at T+44.

Source files
------------

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: multi-cycle RV64M multiply/divide sequencer for the EX stage.
// A shift-add multiplier and a restoring divider share one 2*DATA_W accumulator
// and retire one bit per cycle. *W ops narrow the operands to 32 bits and
// sign-extend the 32-bit result.
// Optional build macro: MDU_EARLY_OUT_EN (multiply finishes once the remaining
// multiplier bits are zero; the result is unchanged).
module ex_muldiv_seq #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [2:0]        mdu_op,
  input  logic              inst_word,
  input  logic [DATA_W-1:0] mdu_src1,
  input  logic [DATA_W-1:0] mdu_src2,
  input  logic              mdu_flush,
  output logic              mdu_res_valid,
  input  logic              mdu_res_ready,
  output logic [DATA_W-1:0] mdu_res_data,
  output logic              mdu_busy
);
  localparam int unsigned AW = 2 * DATA_W;
  localparam int unsigned WW = 32;
  localparam logic [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] WMIN = {{(DATA_W-WW+1){1'b1}}, {(WW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              word_q, word_d;
  logic              neg_q, neg_d;      // negate product / quotient
  logic              rneg_q, rneg_d;    // negate remainder
  logic [DATA_W-1:0] mcand_q, mcand_d;  // multiplicand or divisor magnitude
  logic [AW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] res_q, res_d;

  logic              is_div, sgn_word, s1_sgn, s2_sgn, neg1, neg2, div_zero, ovf;
  logic [DATA_W-1:0] op1, op2, mag1, mag2;

  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W:0]   mul_sum, div_trial;
  logic [AW-1:0]     mul_acc, div_acc, prod, prod_s;
  logic [CNT_W:0]    sh;
  logic              mul_fin;
  logic [DATA_W-1:0] mul_res, quo, rmd, div_res;

  function automatic logic [DATA_W-1:0] wfix(input logic w, input logic [DATA_W-1:0] r);
    return w ? {{(DATA_W-WW){r[WW-1]}}, r[WW-1:0]} : r;
  endfunction

  assign mdu_ready     = (state_q == IDLE);
  assign mdu_res_valid = (state_q == DONE);
  assign mdu_busy      = (state_q != IDLE);
  assign mdu_res_data  = res_q;

  // Operand narrowing, sign detection, magnitudes and early-exit divide cases
  always_comb begin
    is_div   = mdu_op[2];
    sgn_word = !(is_div && mdu_op[0]);
    op1      = mdu_src1;
    op2      = mdu_src2;
    if (inst_word) begin
      op1 = sgn_word ? {{(DATA_W-WW){mdu_src1[WW-1]}}, mdu_src1[WW-1:0]}
                     : {{(DATA_W-WW){1'b0}}, mdu_src1[WW-1:0]};
      op2 = sgn_word ? {{(DATA_W-WW){mdu_src2[WW-1]}}, mdu_src2[WW-1:0]}
                     : {{(DATA_W-WW){1'b0}}, mdu_src2[WW-1:0]};
    end
    s1_sgn   = is_div ? !mdu_op[0] : (inst_word || (mdu_op[1:0] != 2'b11));
    s2_sgn   = is_div ? !mdu_op[0] : (inst_word || !mdu_op[1]);
    neg1     = s1_sgn && op1[DATA_W-1];
    neg2     = s2_sgn && op2[DATA_W-1];
    mag1     = neg1 ? -op1 : op1;
    mag2     = neg2 ? -op2 : op2;
    div_zero = (op2 == '0);
    ovf      = is_div && !mdu_op[0] && (op2 == '1) && (op1 == (inst_word ? WMIN : DMIN));
  end

  // Iteration datapath, result selection and next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    word_d  = word_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;

    cnt_nxt   = cnt_q - CNT_W'(1);
    // Multiply: acc = {partial product, unconsumed multiplier}, shifted right.
    mul_sum   = {1'b0, acc_q[AW-1:DATA_W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_acc   = {mul_sum, acc_q[DATA_W-1:1]};
    // Divide: acc = {partial remainder, dividend/quotient}, shifted left.
    div_trial = acc_q[AW-1:DATA_W-1] - {1'b0, mcand_q};
    div_acc   = div_trial[DATA_W] ? {acc_q[AW-2:0], 1'b0}
                                  : {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    // Word products finish 32 bits short of full alignment.
    sh        = word_q ? (CNT_W+1)'(WW) : '0;
`ifdef MDU_EARLY_OUT_EN
    // Remaining multiplier bits sit in acc[cnt_nxt-1:0]; once zero, the
    // product just needs the outstanding shifts applied.
    sh        = sh + {1'b0, cnt_nxt};
    mul_fin   = (mul_acc[DATA_W-1:0] & ~({DATA_W{1'b1}} << cnt_nxt)) == '0;
`else
    mul_fin   = (cnt_q == CNT_W'(1));
`endif
    prod      = mul_acc >> sh;
    prod_s    = neg_q ? -prod : prod;
    mul_res   = (!word_q && op_q != OP_MUL) ? prod_s[AW-1:DATA_W] : prod_s[DATA_W-1:0];
    quo       = neg_q  ? -div_acc[DATA_W-1:0]  : div_acc[DATA_W-1:0];
    rmd       = rneg_q ? -div_acc[AW-1:DATA_W] : div_acc[AW-1:DATA_W];
    div_res   = (op_q inside {OP_REM, OP_REMU}) ? rmd : quo;

    case (state_q)
      IDLE: begin
        if (mdu_valid && !mdu_flush) begin
          op_d   = op_e'(mdu_op);
          word_d = inst_word;
          cnt_d  = inst_word ? CNT_W'(WW) : CNT_W'(DATA_W);
          neg_d  = neg1 ^ neg2;
          rneg_d = neg1;
          if (is_div) begin
            if (div_zero) begin
              state_d = DONE;
              res_d   = wfix(inst_word, mdu_op[1] ? op1 : '1);
            end else if (ovf) begin
              state_d = DONE;
              res_d   = wfix(inst_word, mdu_op[1] ? '0 : op1);
            end else begin
              state_d = DIV;
              mcand_d = mag2;
              acc_d   = {{DATA_W{1'b0}},
                         inst_word ? {mag1[WW-1:0], {(DATA_W-WW){1'b0}}} : mag1};
            end
          end else begin
            state_d = MUL;
            mcand_d = mag1;
            acc_d   = {{DATA_W{1'b0}}, mag2};
`ifdef MDU_EARLY_OUT_EN
            if (mag2 == '0) begin
              state_d = DONE;
              res_d   = '0;
            end
`endif
          end
        end
      end
      MUL: begin
        if (mdu_flush) begin
          state_d = IDLE;
        end else begin
          acc_d = mul_acc;
          cnt_d = cnt_nxt;
          if (mul_fin) begin
            state_d = DONE;
            res_d   = wfix(word_q, mul_res);
          end
        end
      end
      DIV: begin
        if (mdu_flush) begin
          state_d = IDLE;
        end else begin
          acc_d = div_acc;
          cnt_d = cnt_nxt;
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            res_d   = wfix(word_q, div_res);
          end
        end
      end
      DONE: begin
        if (mdu_flush || mdu_res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      word_q  <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      word_q  <= word_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb_ex_muldiv_seq: table-driven vectors with a result scoreboard, plus
// hand-written sequences for hold, flush and reset corner cases.
module tb_ex_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [2:0]  mdu_op;
  logic        inst_word;
  logic [63:0] mdu_src1;
  logic [63:0] mdu_src2;
  logic        mdu_flush;
  logic        mdu_res_valid;
  logic        mdu_res_ready;
  logic [63:0] mdu_res_data;
  logic        mdu_busy;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [63:0] sb[$];

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        word;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] exp;
    int unsigned lat;   // cycles from accept to res_valid
  } vec_t;

  vec_t vecs[18];

  ex_muldiv_seq #(.DATA_W(64), .CNT_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .mdu_valid    (mdu_valid),
    .mdu_ready    (mdu_ready),
    .mdu_op       (mdu_op),
    .inst_word    (inst_word),
    .mdu_src1     (mdu_src1),
    .mdu_src2     (mdu_src2),
    .mdu_flush    (mdu_flush),
    .mdu_res_valid(mdu_res_valid),
    .mdu_res_ready(mdu_res_ready),
    .mdu_res_data (mdu_res_data),
    .mdu_busy     (mdu_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic w, input logic [63:0] s1,
                       input logic [63:0] s2);
    mdu_op    = op;
    inst_word = w;
    mdu_src1  = s1;
    mdu_src2  = s2;
    mdu_valid = 1'b1;
  endtask

  // Called #1 after the accept edge: wait for the result, check latency and
  // data against the scoreboard, then consume it.
  task automatic finish_op(input string name, input int unsigned exp_lat);
    int unsigned k = 0;
    while (!mdu_res_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, " latency"}, 64'(k + 1), 64'(exp_lat));
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard: got empty, want an entry", name);
    end else begin
      chk({name, " data"}, mdu_res_data, sb.pop_front());
    end
    if (!mdu_res_valid) begin
      mdu_flush = 1'b1;
      @(posedge clk);
      #1 mdu_flush = 1'b0;
    end
    mdu_res_ready = 1'b1;
    @(posedge clk);
    #1 mdu_res_ready = 1'b0;
    chk({name, " busy after handshake"}, 64'(mdu_busy), 64'(0));
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.op, v.word, v.s1, v.s2);
    @(posedge clk);
    sb.push_back(v.exp);
    #1 mdu_valid = 1'b0;
    finish_op(v.name, v.lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"MUL",        3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{"MULHU",      3'd3, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'h6, 65};
    vecs[2]  = '{"DIVW ovf",   3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[3]  = '{"REMW ovf",   3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1};
    vecs[4]  = '{"DIVU by 0",  3'd5, 1'b0, 64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[5]  = '{"REMU by 0",  3'd7, 1'b0, 64'h1234, 64'h0, 64'h1234, 1};
    vecs[6]  = '{"REM -7,2",   3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[7]  = '{"DIVUW",      3'd5, 1'b1, 64'hFFFF_FFFF, 64'd2, 64'h7FFF_FFFF, 33};
    vecs[8]  = '{"DIV 100,-7", 3'd4, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65};
    vecs[9]  = '{"REM 100,-7", 3'd6, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65};
    vecs[10] = '{"MULH min^2", 3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 65};
    vecs[11] = '{"MULHSU",     3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[12] = '{"DIVW -7,2",  3'd4, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    vecs[13] = '{"DIV ovf",    3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[14] = '{"REMUW by 0", 3'd7, 1'b1, 64'h0000_0001_8000_0001, 64'h0, 64'hFFFF_FFFF_8000_0001, 1};
    vecs[15] = '{"MULW -1,5",  3'd0, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 33};
    vecs[16] = '{"MUL 2^64",   3'd0, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'h0, 65};
    vecs[17] = '{"MULHU 2^64", 3'd3, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1, 65};

    rst           = 1'b1;
    mdu_valid     = 1'b0;
    mdu_op        = 3'd0;
    inst_word     = 1'b0;
    mdu_src1      = '0;
    mdu_src2      = '0;
    mdu_flush     = 1'b0;
    mdu_res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset ready",     64'(mdu_ready),     64'(1));
    chk("reset res_valid", 64'(mdu_res_valid), 64'(0));
    chk("reset res_data",  mdu_res_data,       64'h0);
    chk("reset busy",      64'(mdu_busy),      64'(0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Result held while EX stalls
    @(negedge clk);
    drive(3'd5, 1'b0, 64'd100, 64'd7);
    @(posedge clk);
    #1 mdu_valid = 1'b0;
    begin
      int unsigned k = 0;
      while (!mdu_res_valid && k < 200) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("hold latency", 64'(k + 1), 64'(65));
    end
    for (int unsigned c = 0; c < 5; c++) begin
      chk("hold res_valid", 64'(mdu_res_valid), 64'(1));
      chk("hold data",      mdu_res_data,       64'd14);
      chk("hold busy",      64'(mdu_busy),      64'(1));
      chk("hold ready",     64'(mdu_ready),     64'(0));
      @(posedge clk);
      #1;
    end
    mdu_res_ready = 1'b1;
    @(posedge clk);
    #1 mdu_res_ready = 1'b0;
    chk("release busy",      64'(mdu_busy),      64'(0));
    chk("release ready",     64'(mdu_ready),     64'(1));
    chk("release res_valid", 64'(mdu_res_valid), 64'(0));

    // Flush in the middle of a divide, then a MULW right behind it
    @(negedge clk);
    drive(3'd4, 1'b0, 64'd1000, 64'd3);
    @(posedge clk);
    #1 mdu_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 mdu_flush = 1'b1;
    chk("pre-flush busy", 64'(mdu_busy), 64'(1));
    @(posedge clk);
    #1 mdu_flush = 1'b0;
    chk("flush busy",      64'(mdu_busy),      64'(0));
    chk("flush res_valid", 64'(mdu_res_valid), 64'(0));
    drive(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2);
    @(posedge clk);
    sb.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    #1 mdu_valid = 1'b0;
    finish_op("MULW after flush", 33);

    // Flush wins over a simultaneous request
    @(negedge clk);
    drive(3'd0, 1'b0, 64'd3, 64'd3);
    mdu_flush = 1'b1;
    @(posedge clk);
    #1 begin
      mdu_valid = 1'b0;
      mdu_flush = 1'b0;
    end
    chk("flush beats accept busy", 64'(mdu_busy), 64'(0));

    // Flush coinciding with the DONE handshake
    @(negedge clk);
    drive(3'd5, 1'b0, 64'h55, 64'h0);
    @(posedge clk);
    #1 mdu_valid = 1'b0;
    chk("done flush res_valid", 64'(mdu_res_valid), 64'(1));
    chk("done flush data",      mdu_res_data,       64'hFFFF_FFFF_FFFF_FFFF);
    mdu_flush     = 1'b1;
    mdu_res_ready = 1'b1;
    @(posedge clk);
    #1 begin
      mdu_flush     = 1'b0;
      mdu_res_ready = 1'b0;
    end
    chk("done flush busy",     64'(mdu_busy),      64'(0));
    chk("done flush valid",    64'(mdu_res_valid), 64'(0));

    // Reset mid-multiply clears the held result
    @(negedge clk);
    drive(3'd0, 1'b0, 64'd9, 64'd9);
    @(posedge clk);
    #1 mdu_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid reset busy",  64'(mdu_busy),  64'(0));
    chk("mid reset ready", 64'(mdu_ready), 64'(1));
    chk("mid reset data",  mdu_res_data,   64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
